// File: rtl/dcache_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dcache_pkg                                                     |
// | Brief   : Shared constants, FSM state codes and address-field helpers    |
// |           for the direct-mapped write-back data cache.                   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package dcache_pkg;

    localparam int c_ADDR_W         = 32;
    localparam int c_NUM_LINES      = 16;
    localparam int c_OFFSET_W       = 5;
    localparam int c_WORD_W         = 32;
    localparam int c_WORDS_PER_LINE = 8;
    localparam int c_WORD_SEL_W     = 3;
    localparam int c_IDX_W          = $clog2(c_NUM_LINES);
    localparam int c_TAG_W          = c_ADDR_W - c_OFFSET_W - c_IDX_W;

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_WRITEBACK = 2'd1;
    localparam logic [1:0] c_ST_REFILL    = 2'd2;

    // Helpers take the index width so any power-of-two line count works.
    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int idx_w);
        return addr >> (c_OFFSET_W + idx_w);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int idx_w);
        return (addr >> c_OFFSET_W) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [c_WORD_SEL_W-1:0] addr_word(input logic [31:0] addr);
        return addr[c_OFFSET_W-1:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_sram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dcache_sram                                                    |
// | Brief   : Valid/dirty/tag/data arrays with combinational read and a      |
// |           single-port edge write (line fill or word-merged store).       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int LINE_BITS = 256,
    parameter int IDX_W     = 4,
    parameter int TAG_W     = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [IDX_W-1:0]        i_idx,
    output logic                    o_valid,
    output logic                    o_dirty,
    output logic [TAG_W-1:0]        o_tag,
    output logic [LINE_BITS-1:0]    o_line,
    input  logic                    i_fill_en,
    input  logic [TAG_W-1:0]        i_fill_tag,
    input  logic [LINE_BITS-1:0]    i_fill_line,
    input  logic                    i_store_en,
    input  logic [c_WORD_SEL_W-1:0] i_store_word,
    input  logic [c_WORD_W-1:0]     i_store_data
);

    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [LINE_BITS-1:0] r_data [NUM_LINES];

    assign o_valid = r_valid[i_idx];
    assign o_dirty = r_dirty[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_line  = r_data[i_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_en) begin
            r_valid[i_idx] <= 1'b1;
            r_dirty[i_idx] <= 1'b0;
        end else if (i_store_en) begin
            r_dirty[i_idx] <= 1'b1;
        end
    end

    // Payload arrays need no reset: valid gates every use of them.
    always_ff @(posedge clk) begin
        if (i_fill_en) begin
            r_tag[i_idx]  <= i_fill_tag;
            r_data[i_idx] <= i_fill_line;
        end else if (i_store_en) begin
            r_data[i_idx][i_store_word*c_WORD_W +: c_WORD_W] <= i_store_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dcache_controller                                              |
// | Brief   : Direct-mapped write-back write-allocate data cache with a      |
// |           line-wide req/ack memory port. DCACHE_STATS_EN adds counters.  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int LINE_BITS = 256,
    parameter int ADDR_W    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic [ADDR_W-1:0]    cpu_addr_i,
    input  logic [31:0]          cpu_wdata_i,
    output logic [31:0]          cpu_rdata_o,
    output logic                 cpu_stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [LINE_BITS-1:0] mem_wdata_o,
    input  logic [LINE_BITS-1:0] mem_rdata_i,
    input  logic                 mem_ack_i,
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o
);

    localparam int c_LINE_IDX_W = $clog2(NUM_LINES);
    localparam int c_LINE_TAG_W = ADDR_W - c_OFFSET_W - c_LINE_IDX_W;

    logic [31:0]              w_addr32;
    logic [31:0]              w_tag_full;
    logic [31:0]              w_idx_full;
    logic [c_LINE_TAG_W-1:0]  w_req_tag;
    logic [c_LINE_IDX_W-1:0]  w_req_idx;
    logic [c_WORD_SEL_W-1:0]  w_req_word;
    logic                     w_unused_bits;

    logic                     w_line_valid;
    logic                     w_line_dirty;
    logic [c_LINE_TAG_W-1:0]  w_line_tag;
    logic [LINE_BITS-1:0]     w_line_data;

    logic                     w_hit;
    logic                     w_miss;
    logic                     w_store_en;
    logic                     w_fill_en;

    logic [1:0]               r_state;
    logic                     r_mem_req;
    logic                     r_mem_we;
    logic [ADDR_W-1:0]        r_mem_addr;
    logic [LINE_BITS-1:0]     r_mem_wdata;

    assign w_addr32      = 32'(cpu_addr_i);
    assign w_tag_full    = addr_tag(w_addr32, c_LINE_IDX_W);
    assign w_idx_full    = addr_index(w_addr32, c_LINE_IDX_W);
    assign w_req_tag     = w_tag_full[c_LINE_TAG_W-1:0];
    assign w_req_idx     = w_idx_full[c_LINE_IDX_W-1:0];
    assign w_req_word    = addr_word(w_addr32);
    assign w_unused_bits = ^{w_tag_full[31:c_LINE_TAG_W], w_idx_full[31:c_LINE_IDX_W], cpu_addr_i[1:0]};

    assign w_hit      = (r_state == c_ST_IDLE) && cpu_req_i && w_line_valid && (w_line_tag == w_req_tag);
    assign w_miss     = (r_state == c_ST_IDLE) && cpu_req_i && !w_hit;
    assign w_store_en = w_hit && cpu_we_i && !rst_i;
    assign w_fill_en  = (r_state == c_ST_REFILL) && mem_ack_i && !rst_i;

    assign cpu_stall_o = (r_state != c_ST_IDLE) || w_miss;
    assign cpu_rdata_o = (w_hit && !cpu_we_i) ? w_line_data[w_req_word*c_WORD_W +: c_WORD_W] : 32'd0;

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;

    dcache_sram #(
        .NUM_LINES (NUM_LINES),
        .LINE_BITS (LINE_BITS),
        .IDX_W     (c_LINE_IDX_W),
        .TAG_W     (c_LINE_TAG_W)
    ) u_sram (
        .clk          (clk_i),
        .rst          (rst_i),
        .i_idx        (w_req_idx),
        .o_valid      (w_line_valid),
        .o_dirty      (w_line_dirty),
        .o_tag        (w_line_tag),
        .o_line       (w_line_data),
        .i_fill_en    (w_fill_en),
        .i_fill_tag   (w_req_tag),
        .i_fill_line  (mem_rdata_i),
        .i_store_en   (w_store_en),
        .i_store_word (w_req_word),
        .i_store_data (cpu_wdata_i)
    );

    // Memory-side outputs are registered so they hold steady until the ack edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_miss) begin
                        r_mem_req <= 1'b1;
                        if (w_line_valid && w_line_dirty) begin
                            r_state     <= c_ST_WRITEBACK;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= {w_line_tag, w_req_idx, {c_OFFSET_W{1'b0}}};
                            r_mem_wdata <= w_line_data;
                        end else begin
                            r_state    <= c_ST_REFILL;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= {w_req_tag, w_req_idx, {c_OFFSET_W{1'b0}}};
                        end
                    end
                end
                c_ST_WRITEBACK: begin
                    if (mem_ack_i) begin
                        r_state     <= c_ST_REFILL;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= {w_req_tag, w_req_idx, {c_OFFSET_W{1'b0}}};
                        r_mem_wdata <= '0;
                    end
                end
                c_ST_REFILL: begin
                    if (mem_ack_i) begin
                        r_state    <= c_ST_IDLE;
                        r_mem_req  <= 1'b0;
                        r_mem_addr <= '0;
                    end
                end
                default: begin
                    r_state     <= c_ST_IDLE;
                    r_mem_req   <= 1'b0;
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;
    logic        r_after_fill;

    // The hit that completes a refilled access is not counted as a hit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
            r_after_fill <= 1'b0;
        end else begin
            if (w_fill_en) begin
                r_after_fill <= 1'b1;
            end else if (r_state == c_ST_IDLE) begin
                r_after_fill <= 1'b0;
            end
            if (w_hit && !r_after_fill && (r_hit_cnt != 32'hFFFF_FFFF)) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_miss && (r_miss_cnt != 32'hFFFF_FFFF)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`else
    assign hit_cnt_o  = 32'd0;
    assign miss_cnt_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_dcache_controller                                           |
// | Brief   : Randomized self-checking bench with an access-level cache      |
// |           reference model and a latency-programmable memory responder.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_dcache_controller;

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } txn_t;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_wdata_i;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic [255:0] mem_rdata_i;
    logic         mem_ack_i;
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Backing store and access-level reference cache
    logic [255:0] mem [logic [31:0]];
    logic         m_valid [16];
    logic         m_dirty [16];
    logic [26:0]  m_la    [16];
    logic [255:0] m_line  [16];
    int           exp_hits   = 0;
    int           exp_misses = 0;

    always #5 clk_i = ~clk_i;

    dcache_controller u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .hit_cnt_o   (hit_cnt_o),
        .miss_cnt_o  (miss_cnt_o)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        logic [255:0] l;
        if (mem.exists(a)) return mem[a];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = a ^ (32'h0101_0101 * (w + 1));
        return l;
    endfunction

    function automatic logic [31:0] exp_hit_count();
`ifdef DCACHE_STATS_EN
        return 32'(exp_hits);
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_miss_count();
`ifdef DCACHE_STATS_EN
        return 32'(exp_misses);
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    // Called at a falling edge; returns at a falling edge with the request dropped.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd, input int lat);
        txn_t         exp_q[$];
        txn_t         got_q[$];
        int           idx;
        int           w;
        int           exp_stall;
        int           stalls;
        int           tcount;
        bit           acked;
        bit           done;
        logic [26:0]  la;
        logic [31:0]  exp_rd;

        idx       = int'(addr[8:5]);
        w         = int'(addr[4:2]);
        la        = addr[31:5];
        exp_stall = 0;
        exp_rd    = 32'd0;
        if (!(m_valid[idx] && m_la[idx] == la)) begin
            exp_misses++;
            if (m_valid[idx] && m_dirty[idx]) begin
                exp_q.push_back('{1'b1, {m_la[idx], 5'b0}, m_line[idx]});
                exp_stall = 2 * lat + 1;
            end else begin
                exp_stall = lat + 1;
            end
            exp_q.push_back('{1'b0, {la, 5'b0}, 256'd0});
            m_line[idx]  = mem_line({la, 5'b0});
            m_la[idx]    = la;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
        end else begin
            exp_hits++;
        end
        if (we) begin
            m_line[idx][w*32 +: 32] = wd;
            m_dirty[idx] = 1'b1;
        end else begin
            exp_rd = m_line[idx][w*32 +: 32];
        end

        cpu_req_i   = 1'b1;
        cpu_we_i    = we;
        cpu_addr_i  = addr;
        cpu_wdata_i = wd;
        stalls = 0;
        tcount = 0;
        done   = 1'b0;
        for (int c = 0; c < 400; c++) begin
            #1;
            if (!cpu_stall_o) begin
                done = 1'b1;
                break;
            end
            stalls++;
            acked = 1'b0;
            if (mem_req_o) begin
                tcount++;
                if (tcount == 1) got_q.push_back('{mem_we_o, mem_addr_o, mem_wdata_o});
                if (tcount == lat) begin
                    check($sformatf("txn_stable@%h", addr), {mem_we_o, mem_addr_o, mem_wdata_o},
                          {got_q[$].we, got_q[$].addr, got_q[$].wdata});
                    mem_ack_i = 1'b1;
                    if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
                    else          mem_rdata_i = mem_line(mem_addr_o);
                    acked = 1'b1;
                end
            end
            @(posedge clk_i);
            #1;
            mem_ack_i   = 1'b0;
            mem_rdata_i = '0;
            if (acked) tcount = 0;
            @(negedge clk_i);
        end

        check($sformatf("serviced@%h", addr), done, 1'b1);
        check($sformatf("stall@%h", addr), stalls, exp_stall);
        check($sformatf("ntxn@%h", addr), got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("txn_we@%h", addr), got_q[i].we, exp_q[i].we);
            check($sformatf("txn_addr@%h", addr), got_q[i].addr, exp_q[i].addr);
            if (exp_q[i].we) check($sformatf("txn_wdata@%h", addr), got_q[i].wdata, exp_q[i].wdata);
        end
        if (!we && done) check($sformatf("rdata@%h", addr), cpu_rdata_o, exp_rd);
        @(posedge clk_i);
        @(negedge clk_i);
        cpu_req_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] l400;
        logic [255:0] ldump;
        int           tc;

        for (int w = 0; w < 8; w++) l400[w*32 +: 32] = 32'h1111_1111 * (w + 1);
        mem[32'h0000_0400] = l400;
        model_reset();

        rst_i       = 1'b1;
        cpu_req_i   = 1'b0;
        cpu_we_i    = 1'b0;
        cpu_addr_i  = '0;
        cpu_wdata_i = '0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rst_stall", cpu_stall_o, 1'b0);
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_mem_we", mem_we_o, 1'b0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_mem_wdata", mem_wdata_o, 256'd0);
        check("rst_rdata", cpu_rdata_o, 32'd0);
        check("rst_hit_cnt", hit_cnt_o, 32'd0);
        check("rst_miss_cnt", miss_cnt_o, 32'd0);
        @(negedge clk_i);

        // Directed scenarios
        do_access(1'b0, 32'h0000_0400, 32'd0, 10);
        do_access(1'b0, 32'h0000_0404, 32'd0, 10);
        do_access(1'b1, 32'h0000_0408, 32'hDEAD_BEEF, 10);
        do_access(1'b0, 32'h0000_0408, 32'd0, 10);
        do_access(1'b0, 32'h0000_0600, 32'd0, 10);
        ldump = mem[32'h0000_0400];
        check("wb_word2", ldump[2*32 +: 32], 32'hDEAD_BEEF);
        do_access(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 3);
        do_access(1'b0, 32'h0000_0220, 32'd0, 3);
        ldump = mem[32'h0000_0020];
        check("alloc_wb_word0", ldump[31:0], 32'hCAFE_F00D);
        check("cnt_hits_dir", hit_cnt_o, exp_hit_count());
        check("cnt_miss_dir", miss_cnt_o, exp_miss_count());

        // Reset in the middle of a refill
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0000_1040;
        tc = 0;
        for (int c = 0; c < 50 && tc < 3; c++) begin
            #1;
            if (mem_req_o) tc++;
            @(negedge clk_i);
        end
        #1;
        check("rst_txn_seen", tc, 3);
        check("rst_txn_is_fill", mem_we_o, 1'b0);
        rst_i     = 1'b1;
        cpu_req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("midrst_mem_req", mem_req_o, 1'b0);
        check("midrst_stall", cpu_stall_o, 1'b0);
        check("midrst_hit_cnt", hit_cnt_o, 32'd0);
        check("midrst_miss_cnt", miss_cnt_o, 32'd0);
        mem_ack_i   = 1'b1;
        mem_rdata_i = {8{32'h5A5A_5A5A}};
        @(posedge clk_i);
        #1;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        @(negedge clk_i);
        #1;
        check("stray_ack_req", mem_req_o, 1'b0);
        check("stray_ack_stall", cpu_stall_o, 1'b0);
        @(negedge clk_i);
        model_reset();
        do_access(1'b0, 32'h0000_1040, 32'd0, 4);
        do_access(1'b0, 32'h0000_0400, 32'd0, 2);

        // Randomized traffic over three tags per index
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            a = 32'h0001_0000 + (32'($urandom_range(0, 2)) << 9)
                + (32'($urandom_range(0, 15)) << 5) + (32'($urandom_range(0, 7)) << 2);
            do_access(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(1, 6)));
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end
        #1;
        check("cnt_hits_end", hit_cnt_o, exp_hit_count());
        check("cnt_miss_end", miss_cnt_o, exp_miss_count());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
